// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the sequence detector.
// Accepts WIDTH-bit words on a valid/ready handshake, keeps one word in a
// hold register while the shifter is busy, and emits one bit per clock on
// ser_out with selectable bit order, idle level and inter-word gap.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0,
    parameter int unsigned GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             busy,
    output logic             word_done,
    output logic [7:0]       words_sent
);

    localparam int unsigned   BW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);
    localparam bit            HAS_GAP   = (GAP > 0);
    localparam logic [3:0]    GCNT_LAST = HAS_GAP ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [BW-1:0]    r_bcnt;
    logic [3:0]       r_gcnt;
    logic [7:0]       r_words_sent;

    logic             w_xfer;
    logic             w_last_bit;
    logic             w_gap_end;
    logic             w_free;
    logic             w_load;
    logic             w_load_hold;
    logic             w_load_din;
    logic             w_out_bit;
    logic [WIDTH-1:0] w_sr_shifted;

    // Handshake and load decisions, all derived from registered state
    always_comb begin
        w_xfer       = din_valid && !r_hold_full;
        w_last_bit   = (r_state == ST_SHIFT) && (r_bcnt == BCNT_LAST);
        w_gap_end    = HAS_GAP && (r_state == ST_GAP) && (r_gcnt == GCNT_LAST);
        w_free       = (r_state == ST_IDLE) || (w_last_bit && !HAS_GAP) || w_gap_end;
        w_load       = w_free && (r_hold_full || w_xfer);
        w_load_hold  = w_load && r_hold_full;
        w_load_din   = w_load && !r_hold_full;
        w_out_bit    = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
        w_sr_shifted = MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load) w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_last_bit) begin
                    if (HAS_GAP)     w_state_next = ST_GAP;
                    else if (w_load) w_state_next = ST_SHIFT;
                    else             w_state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (w_gap_end) w_state_next = w_load ? ST_SHIFT : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs and status
    always_comb begin
        busy       = (r_state == ST_SHIFT);
        word_done  = w_last_bit;
        ser_out    = (r_state == ST_SHIFT) ? w_out_bit : IDLE_BIT;
        din_ready  = !r_hold_full;
        words_sent = r_words_sent;
    end

    // Shift register and bit counter: load takes priority over shifting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr   <= '0;
            r_bcnt <= '0;
        end else if (w_load) begin
            r_sr   <= r_hold_full ? r_hold : din;
            r_bcnt <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_sr   <= w_sr_shifted;
            r_bcnt <= w_last_bit ? '0 : r_bcnt + 1'b1;
        end
    end

    // Gap counter: cleared on the last bit, counts through the gap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gcnt <= '0;
        end else if (w_last_bit && HAS_GAP) begin
            r_gcnt <= '0;
        end else if (r_state == ST_GAP) begin
            r_gcnt <= w_gap_end ? 4'd0 : r_gcnt + 4'd1;
        end
    end

    // Hold register: a transfer that does not go straight into the shifter
    // lands here; a load from hold frees it unless refilled on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_xfer && !w_load_din) begin
            r_hold      <= din;
            r_hold_full <= 1'b1;
        end else if (w_load_hold) begin
            r_hold_full <= 1'b0;
        end
    end

    // Completed-word counter, wraps modulo 256
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_words_sent <= '0;
        end else if (w_last_bit) begin
            r_words_sent <= r_words_sent + 8'd1;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three instances (MSB-first no gap, LSB-first
// idle-high no gap, MSB-first gap of 2) driven with directed and random
// words, compared each cycle against a timeline model of accepted words.
module tb_bit_serializer;

    localparam int W = 8;
    localparam int N = 3;

    function automatic bit msbf(input int d);
        return (d != 1);
    endfunction

    function automatic bit idlb(input int d);
        return (d == 1);
    endfunction

    function automatic int gapv(input int d);
        return (d == 2) ? 2 : 0;
    endfunction

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din_a [N];
    logic       val   [N];
    logic       rdy   [N];
    logic       ser   [N];
    logic       bsy   [N];
    logic       wd    [N];
    logic [7:0] ws    [N];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst_n), .din(din_a[0]), .din_valid(val[0]), .din_ready(rdy[0]),
        .ser_out(ser[0]), .busy(bsy[0]), .word_done(wd[0]), .words_sent(ws[0]));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .GAP(0)) u_dut1 (
        .clk(clk), .rst(rst_n), .din(din_a[1]), .din_valid(val[1]), .din_ready(rdy[1]),
        .ser_out(ser[1]), .busy(bsy[1]), .word_done(wd[1]), .words_sent(ws[1]));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP(2)) u_dut2 (
        .clk(clk), .rst(rst_n), .din(din_a[2]), .din_valid(val[2]), .din_ready(rdy[2]),
        .ser_out(ser[2]), .busy(bsy[2]), .word_done(wd[2]), .words_sent(ws[2]));

    // Each accepted word: acceptance edge, first-bit cycle, data
    typedef struct {
        int         a;
        int         s;
        logic [7:0] w;
    } ent_t;

    ent_t        mq [N][$];
    logic [7:0]  dq [N][$];
    int          last_s [N];
    logic [7:0]  ews [N];
    logic [31:0] cap [N];
    int          t;
    int          n_chk;
    int          n_pass;
    int          rnd_pct;
    int          lowcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    task automatic model_clear();
        for (int d = 0; d < N; d++) begin
            mq[d].delete();
            dq[d].delete();
            last_s[d] = -100;
            ews[d]    = 8'd0;
            val[d]    = 1'b0;
            din_a[d]  = 8'd0;
        end
    endtask

    // One clock: compare all outputs against the model, then drive inputs
    task automatic step();
        bit         e_busy, e_bit, e_done, e_rdy, v;
        logic [7:0] dd;
        int         k, ns;
        ent_t       e;
        @(posedge clk);
        #1;
        t++;
        for (int d = 0; d < N; d++) begin
            while (mq[d].size() > 0 && mq[d][0].s + W - 1 < t) void'(mq[d].pop_front());
            e_busy = 1'b0;
            e_bit  = idlb(d);
            e_done = 1'b0;
            e_rdy  = 1'b1;
            for (int i = 0; i < mq[d].size(); i++) begin
                if (mq[d][i].s <= t && t <= mq[d][i].s + W - 1) begin
                    k      = t - mq[d][i].s;
                    e_busy = 1'b1;
                    e_bit  = msbf(d) ? mq[d][i].w[W-1-k] : mq[d][i].w[k];
                    e_done = (k == W - 1);
                end
                if (mq[d][i].a <= t && t < mq[d][i].s) e_rdy = 1'b0;
            end
            chk($sformatf("d%0d_ser_out", d), 32'(ser[d]), 32'(e_bit));
            chk($sformatf("d%0d_busy", d), 32'(bsy[d]), 32'(e_busy));
            chk($sformatf("d%0d_word_done", d), 32'(wd[d]), 32'(e_done));
            chk($sformatf("d%0d_din_ready", d), 32'(rdy[d]), 32'(e_rdy));
            chk($sformatf("d%0d_words_sent", d), 32'(ws[d]), 32'(ews[d]));
            if (e_busy) cap[d] = {cap[d][30:0], ser[d]};
            if (d == 0 && !rdy[0]) lowcnt++;
            if (e_done) ews[d] = ews[d] + 8'd1;

            dd = 8'($urandom);
            if (dq[d].size() > 0) begin
                v  = 1'b1;
                dd = dq[d][0];
            end else if (rnd_pct > 0) begin
                v = ($urandom_range(0, 99) < rnd_pct);
            end else begin
                v = 1'b0;
            end
            val[d]   = v;
            din_a[d] = dd;
            if (v && e_rdy) begin
                ns = last_s[d] + W + gapv(d);
                if (ns < t + 1) ns = t + 1;
                e.a = t + 1;
                e.s = ns;
                e.w = dd;
                mq[d].push_back(e);
                last_s[d] = ns;
                if (dq[d].size() > 0) void'(dq[d].pop_front());
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_caps();
        for (int d = 0; d < N; d++) cap[d] = '0;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        t       = 0;
        rnd_pct = 0;
        lowcnt  = 0;
        clear_caps();
        model_clear();

        // Reset state
        run(3);
        rst_n = 1'b1;
        run(2);

        // Single words
        clear_caps();
        dq[0].push_back(8'hA5);
        dq[1].push_back(8'h01);
        dq[2].push_back(8'hA5);
        run(14);
        chk("msb_a5_stream", cap[0], 32'h0000_00A5);
        chk("lsb_01_stream", cap[1], 32'h0000_0080);
        chk("gap_a5_stream", cap[2], 32'h0000_00A5);
        chk("single_words_sent", 32'(ws[0]), 32'd1);

        // Two words with valid held high
        clear_caps();
        lowcnt = 0;
        dq[0].push_back(8'hF0);
        dq[0].push_back(8'h0F);
        dq[2].push_back(8'hF0);
        dq[2].push_back(8'h0F);
        run(26);
        chk("pair_stream", cap[0], 32'h0000_F00F);
        chk("pair_gap_stream", cap[2], 32'h0000_F00F);
        chk("pair_backpressure", 32'(lowcnt > 0), 32'd1);
        chk("pair_words_sent", 32'(ws[0]), 32'd3);

        // Random traffic at two densities, then drain
        rnd_pct = 70;
        run(800);
        rnd_pct = 25;
        run(400);
        rnd_pct = 0;
        run(30);

        // Reset after the third bit of 8'hFF with 8'h55 held
        for (int d = 0; d < N; d++) begin
            dq[d].push_back(8'hFF);
            dq[d].push_back(8'h55);
        end
        run(4);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < N; d++) begin
            chk($sformatf("d%0d_rst_ser_out", d), 32'(ser[d]), 32'(idlb(d)));
            chk($sformatf("d%0d_rst_din_ready", d), 32'(rdy[d]), 32'd1);
            chk($sformatf("d%0d_rst_words_sent", d), 32'(ws[d]), 32'd0);
            chk($sformatf("d%0d_rst_busy", d), 32'(bsy[d]), 32'd0);
        end
        model_clear();
        run(2);
        rst_n = 1'b1;
        run(12);

        // 256 back-to-back words: counter wraps to 0 with no stalls
        for (int i = 0; i < 256; i++) begin
            dq[0].push_back(8'($urandom));
            dq[1].push_back(8'($urandom));
        end
        run(256 * W + 10);
        chk("wrap_words_sent_d0", 32'(ws[0]), 32'd0);
        chk("wrap_words_sent_d1", 32'(ws[1]), 32'd0);

        rnd_pct = 50;
        run(300);
        rnd_pct = 0;
        run(30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the sequence-detector FSM. It accepts WIDTH-bit words over a valid/ready handshake, buffers up to one word ahead, and shifts each word out one bit per clock on `ser_out`. `ser_out` drives the detector's serial `in` input directly. Configurable bit order, idle level and inter-word gap; a running word count feeds debug status.

## Interface
- WIDTH, 8, word width in bits (2..32)
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first
- IDLE_BIT, 0, level of `ser_out` when no word is being shifted
- GAP, 0, idle cycles inserted between consecutive words (0..15)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- din  input  WIDTH  word to serialize
- din_valid  input  1  `din` valid this cycle
- din_ready  output  1  block can accept a word this cycle
- ser_out  output  1  serial bit stream
- busy  output  1  shifter holds a word (state SHIFT)
- word_done  output  1  high during the cycle carrying the last bit of a word
- words_sent  output  8  count of completed words, wraps 255 -> 0

## Operation
- Storage:
  - shift register `sr` [WIDTH]
  - one-deep hold register `hold` plus `hold_full`
  - bit counter `bcnt` (0..WIDTH-1)
  - gap counter `gcnt` (0..GAP-1)
- Transfer occurs on an edge where `din_valid && din_ready`.
- `din_ready = !hold_full`. It is a register-derived value with no combinational path from `din_valid`.
- FSM states: IDLE, SHIFT, GAP.
- `free` (the shifter can load at this edge) is true in any of these cases:
  - state IDLE
  - state SHIFT with `bcnt==WIDTH-1` and GAP==0
  - state GAP with `gcnt==GAP-1`
- Load at a `free` edge:
  - Source is `hold` if `hold_full`, else `din` if a transfer occurs this edge.
  - On load: `sr`<=source, `bcnt`<=0, state<=SHIFT.
  - If the source is `hold`: `hold_full` clears, unless a transfer occurs the same edge, in which case `din` enters `hold` and `hold_full` stays 1.
- Transfer at a non-`free` edge (or a `free` edge where `hold` was loaded): `din` is written to `hold` and `hold_full`<=1.
- SHIFT:
  - `ser_out` = `sr[WIDTH-1]` if MSB_FIRST, else `sr[0]`.
  - Each edge, shift toward the output bit and increment `bcnt`.
  - At `bcnt==WIDTH-1`: if GAP>0, go to GAP with `gcnt`<=0; else load if a source exists, otherwise go to IDLE.
- GAP: `ser_out`=IDLE_BIT. Increment `gcnt`; at `gcnt==GAP-1`, load if a source exists, else go to IDLE.
- IDLE: `ser_out`=IDLE_BIT.
- `word_done` = (state==SHIFT && `bcnt==WIDTH-1`).
- `words_sent` increments by 1 (mod 256) on each edge where `word_done` is high.
- `busy` = (state==SHIFT).

## Timing
- Reset (`rst`=0, async) forces:
  - state IDLE, `hold_full`=0, `bcnt`=0, `gcnt`=0, `sr`=0
  - `words_sent`=0, `word_done`=0, `busy`=0
  - `ser_out`=IDLE_BIT, `din_ready`=1
  
  Reset mid-word discards the partial word and the held word; no `word_done` is produced for either. Release is synchronous to the next rising edge.
- Latency: word accepted at edge N while IDLE puts its first bit on `ser_out` in cycle N+1 (the cycle following edge N). The last bit appears in cycle N+WIDTH, with `word_done` high in that cycle. `words_sent` updates at edge N+WIDTH.
- Back-to-back with GAP==0: zero bubble. Bit 0 of the next word follows the last bit of the previous word in the next cycle.
- With GAP>0: exactly GAP cycles of IDLE_BIT between words.
- Sustained input at GAP==0: one word per WIDTH cycles. `din_ready` is low whenever `hold_full`.
- Simultaneous load-from-hold and new transfer: both take effect with no word lost or duplicated.

## Test plan
- WIDTH=8, MSB_FIRST=1, GAP=0, single word 8'hA5 accepted at edge N:
  - `ser_out` = 1,0,1,0,0,1,0,1 in cycles N+1..N+8, then 0
  - `word_done` high only in cycle N+8; `words_sent`=1
- Same configuration with MSB_FIRST=0, word 8'h01: `ser_out` = 1,0,0,0,0,0,0,0.
- Words 8'hF0 then 8'h0F, with `din_valid` held high:
  - 16 contiguous bits 1111000000001111
  - `din_ready` low while `hold` is full
  - `words_sent`=2
- GAP=2, same two words: 8 bits, then 2 IDLE_BIT cycles, then 8 bits. Second word's first bit appears exactly 10 cycles after the first word's first bit.
- Assert `rst`=0 after the 3rd bit of 8'hFF while 8'h55 is held:
  - `ser_out` drops to IDLE_BIT immediately
  - `din_ready`=1 and `words_sent`=0
  - no further bits appear after release
- 256 consecutive words: `words_sent` reads 255 after 255 words and 0 after the 256th. No handshake stall occurs beyond `hold_full` backpressure.
